// File: rtl/mem_arbiter_if.sv
// Buses around the fetch/data memory arbiter: the two requesters and the shared memory.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface mem_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic [WIDTH-1:0] if_rdata;
  logic             if_done;
  logic             dm_req;
  logic             dm_we;
  logic [WIDTH-1:0] dm_addr;
  logic [WIDTH-1:0] dm_wdata;
  logic [WIDTH-1:0] dm_rdata;
  logic             dm_done;
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_done, dm_rdata, dm_done, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_done, dm_rdata, dm_done, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// One access in flight at a time, with a bounded wait that aborts the access and sets a sticky error.
module mem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus,
  output logic          stall,
  output logic          timeout_err
);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] addr_reg, wdata_reg;
  logic [WIDTH-1:0] if_rdata_reg, dm_rdata_reg;
  logic             we_reg, grant_dm_reg, timeout_err_reg;
  logic [CW-1:0]    wait_cnt_reg;
  logic             any_req, pick_dm, wait_expired;

  assign any_req      = bus.if_req | bus.dm_req;
  // grant_dm_reg doubles as the last-grant record: a tie goes to whoever was not served last
  assign pick_dm      = bus.dm_req & (~bus.if_req | ~grant_dm_reg);
  assign wait_expired = (wait_cnt_reg == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = BUSY;
      BUSY:    if (bus.mem_ready || wait_expired) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_reg        <= '0;
      wdata_reg       <= '0;
      we_reg          <= 1'b0;
      grant_dm_reg    <= 1'b0;
      wait_cnt_reg    <= '0;
      if_rdata_reg    <= '0;
      dm_rdata_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            addr_reg     <= pick_dm ? bus.dm_addr : bus.if_addr;
            wdata_reg    <= pick_dm ? bus.dm_wdata : '0;
            we_reg       <= pick_dm & bus.dm_we;
            grant_dm_reg <= pick_dm;
            wait_cnt_reg <= '0;
          end
        end
        BUSY: begin
          if (bus.mem_ready) begin
            if (grant_dm_reg) dm_rdata_reg <= bus.mem_rdata;
            else              if_rdata_reg <= bus.mem_rdata;
          end else if (wait_expired) begin
            // Aborted access completes with zero data
            if (grant_dm_reg) dm_rdata_reg <= '0;
            else              if_rdata_reg <= '0;
            timeout_err_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    bus.if_done = 1'b0;
    bus.dm_done = 1'b0;
    case (state_reg)
      BUSY: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = we_reg;
      end
      DONE: begin
        bus.if_done = ~grant_dm_reg;
        bus.dm_done = grant_dm_reg;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.dm_rdata  = dm_rdata_reg;
  assign timeout_err   = timeout_err_reg;
  assign stall         = (bus.if_req & ~bus.if_done) | (bus.dm_req & ~bus.dm_done);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level reference model checked every cycle,
// plus literal expectations for latency, grant order, timeout and reset behaviour.
module tb_mem_arbiter;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic stall, timeout_err;

  mem_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mem_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .stall      (stall),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // memory responder: ready after resp_delay waiting cycles (-1 = never), or manual drive
  int          resp_delay;
  logic [31:0] resp_data;
  bit          manual, manual_ready;
  int          resp_age = 0;

  always @(posedge clk) begin
    #1;
    bus.mem_rdata = resp_data;
    if (manual) begin
      bus.mem_ready = manual_ready;
    end else if (bus.mem_req === 1'b1) begin
      bus.mem_ready = (resp_age == resp_delay);
      resp_age++;
    end else begin
      bus.mem_ready = 1'b0;
      resp_age = 0;
    end
  end

  int checks, failures;
  int req_total;
  int done_log[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: one pending transaction record and per-requester result words
  bit          m_active, m_done, m_is_dm, m_we, m_last_dm, m_terr;
  int          m_age;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;

  task automatic model_loop();
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_active = 0; m_done = 0; m_is_dm = 0; m_we = 0; m_last_dm = 0; m_terr = 0;
        m_age = 0; m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_dm_rdata = 0;
      end
      if (bus.mem_req === 1'b1) req_total++;
      chk("mem_req", bus.mem_req, m_active);
      chk("mem_we", bus.mem_we, m_active && m_we);
      if (m_active) chk("mem_addr", bus.mem_addr, m_addr);
      if (m_active && m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("if_done", bus.if_done, m_done && !m_is_dm);
      chk("dm_done", bus.dm_done, m_done && m_is_dm);
      chk("if_rdata", bus.if_rdata, m_if_rdata);
      chk("dm_rdata", bus.dm_rdata, m_dm_rdata);
      chk("timeout_err", timeout_err, m_terr);
      chk("stall", stall, (bus.if_req && !(m_done && !m_is_dm)) || (bus.dm_req && !(m_done && m_is_dm)));
      if (reset) begin
        if (m_done) begin
          m_done = 0;
        end else if (m_active) begin
          if (bus.mem_ready) begin
            if (m_is_dm) m_dm_rdata = bus.mem_rdata;
            else         m_if_rdata = bus.mem_rdata;
            m_active = 0; m_done = 1;
          end else if (m_age + 1 == TIMEOUT) begin
            if (m_is_dm) m_dm_rdata = 0;
            else         m_if_rdata = 0;
            m_terr = 1; m_active = 0; m_done = 1;
          end else begin
            m_age++;
          end
        end else if (bus.if_req || bus.dm_req) begin
          m_is_dm   = bus.dm_req && (!bus.if_req || !m_last_dm);
          m_last_dm = m_is_dm;
          m_addr    = m_is_dm ? bus.dm_addr : bus.if_addr;
          m_we      = m_is_dm && bus.dm_we;
          m_wdata   = bus.dm_wdata;
          m_active  = 1; m_age = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // run until n completions; keep=1 leaves requests held across completions
  task automatic serve(input int n, input int budget, input bit keep, input string name, output int cycles);
    int seen = 0;
    cycles = 0;
    while (cycles < budget && seen < n) begin
      tick();
      cycles++;
      if (bus.if_done === 1'b1) begin
        done_log.push_back(0); seen++;
        if (!keep) bus.if_req = 1'b0;
      end
      if (bus.dm_done === 1'b1) begin
        done_log.push_back(1); seen++;
        if (!keep) bus.dm_req = 1'b0;
      end
    end
    if (keep) begin
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
    end
    chk({name, " completions"}, seen, n);
  endtask

  initial begin
    int lat, r0, base, pulses;
    bit exp_seq [4] = '{1, 0, 1, 0};
    checks = 0; failures = 0; req_total = 0;
    bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = 0; bus.dm_wdata = 0;
    resp_delay = 0; resp_data = 0; manual = 0; manual_ready = 0;
    fork
      model_loop();
    join_none
    #1;
    do_reset();

    chk("reset mem_req", bus.mem_req, 0);
    chk("reset timeout_err", timeout_err, 0);
    chk("reset if_rdata", bus.if_rdata, 0);
    chk("reset dm_done", bus.dm_done, 0);

    // single fetch, memory ready in the first busy cycle
    resp_delay = 0; resp_data = 32'h8C0A0004;
    r0 = req_total;
    bus.if_addr = 32'h40; bus.if_req = 1;
    serve(1, 10, 0, "fetch", lat);
    chk("fetch latency", lat, 2);
    chk("fetch if_rdata", bus.if_rdata, 32'h8C0A0004);
    tick();
    chk("fetch mem_req cycles", req_total - r0, 1);
    chk("fetch rdata hold", bus.if_rdata, 32'h8C0A0004);
    $display("fetch: latency=%0d rdata=%h", lat, bus.if_rdata);

    // simultaneous requests straight after reset: data first
    do_reset();
    resp_data = 32'h0000_1234;
    bus.dm_we = 1; bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEADBEEF; bus.dm_req = 1;
    bus.if_addr = 32'h44; bus.if_req = 1;
    base = done_log.size();
    serve(2, 20, 0, "tie", lat);
    if (done_log.size() >= base + 2) begin
      chk("tie first grant", done_log[base], 1);
      chk("tie second grant", done_log[base + 1], 0);
    end
    chk("tie dm_rdata", bus.dm_rdata, 32'h0000_1234);
    tick();
    $display("tie: served in %0d cycles", lat);

    // both requests held: grants alternate D I D I
    bus.dm_we = 0; bus.dm_addr = 32'h104; bus.if_addr = 32'h48; resp_data = 32'h5555;
    bus.dm_req = 1; bus.if_req = 1;
    base = done_log.size();
    serve(4, 40, 1, "alternate", lat);
    for (int i = 0; i < 4; i++)
      if (done_log.size() > base + i) chk("alternate grant order", done_log[base + i], exp_seq[i]);
    tick();
    $display("alternate: 4 accesses in %0d cycles", lat);

    // slow memory: ready after 5 waiting cycles; requester inputs scrambled mid-access
    resp_delay = 5; resp_data = 32'h0BAD_CAFE;
    bus.dm_we = 1; bus.dm_addr = 32'h200; bus.dm_wdata = 32'h12345678; bus.dm_req = 1;
    r0 = req_total;
    tick(); tick(); tick();
    bus.dm_addr = 32'hBAD0; bus.dm_wdata = 32'h0;
    serve(1, 20, 0, "slow", lat);
    chk("slow mem_req cycles", req_total - r0, 6);
    chk("slow timeout_err", timeout_err, 0);
    tick();
    $display("slow: busy cycles=%0d", req_total - r0);

    // memory never ready: abort after TIMEOUT busy cycles
    resp_delay = -1; resp_data = 32'hFFFF0000;
    bus.dm_we = 0; bus.if_addr = 32'h80; bus.if_req = 1;
    r0 = req_total;
    serve(1, 40, 0, "timeout", lat);
    chk("timeout latency", lat, 17);
    chk("timeout mem_req cycles", req_total - r0, 16);
    chk("timeout if_rdata", bus.if_rdata, 0);
    chk("timeout flag", timeout_err, 1);
    tick(); tick(); tick();
    chk("timeout flag sticky", timeout_err, 1);
    resp_delay = 0; resp_data = 32'hCAFEF00D;
    bus.if_addr = 32'h84; bus.if_req = 1;
    serve(1, 10, 0, "after timeout", lat);
    chk("after timeout if_rdata", bus.if_rdata, 32'hCAFEF00D);
    chk("after timeout flag", timeout_err, 1);
    tick();
    $display("timeout: abort latency=%0d flag=%0b", 17, timeout_err);

    // reset during the second busy cycle, then a late ready
    manual = 1; manual_ready = 0;
    bus.dm_we = 0; bus.dm_addr = 32'h300; bus.dm_req = 1;
    tick(); tick();
    chk("busy before reset", bus.mem_req, 1);
    reset = 0; bus.dm_req = 0;
    tick();
    manual_ready = 1;
    tick();
    reset = 1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.if_done === 1'b1 || bus.dm_done === 1'b1) pulses++;
    end
    chk("no done after reset", pulses, 0);
    chk("reset mid-busy mem_req", bus.mem_req, 0);
    chk("reset mid-busy timeout_err", timeout_err, 0);
    chk("reset mid-busy if_rdata", bus.if_rdata, 0);
    manual = 0; manual_ready = 0; resp_delay = 0; resp_data = 32'h77;
    tick();
    bus.dm_addr = 32'h304; bus.dm_req = 1; bus.if_addr = 32'h88; bus.if_req = 1;
    base = done_log.size();
    serve(2, 20, 0, "post-reset tie", lat);
    if (done_log.size() >= base + 2) begin
      chk("post-reset first grant", done_log[base], 1);
      chk("post-reset second grant", done_log[base + 1], 0);
    end
    tick();
    $display("reset in busy: stray done pulses=%0d", pulses);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, address and data width in bits.
REQ-002 Parameter: TIMEOUT, 16, maximum memory wait cycles per access (>=2).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1  instruction-fetch read request; held until if_done.
REQ-006 if_addr  in  WIDTH  fetch address.
REQ-007 if_rdata  out  WIDTH  fetched word; valid while if_done=1.
REQ-008 if_done  out  1  one-cycle completion pulse for fetch.
REQ-009 dm_req  in  1  data-memory request from MEM stage; held until dm_done.
REQ-010 dm_we  in  1  1 = store, 0 = load.
REQ-011 dm_addr, dm_wdata  in  WIDTH each  data address and store data.
REQ-012 dm_rdata  out  WIDTH  load data; valid while dm_done=1.
REQ-013 dm_done  out  1  one-cycle completion pulse for data access.
REQ-014 mem_req, mem_we  out  1 each  request and write-enable to the shared memory.
REQ-015 mem_addr, mem_wdata  out  WIDTH each  address and write data to memory.
REQ-016 mem_rdata  in  WIDTH  memory read data; sampled when mem_ready=1.
REQ-017 mem_ready  in  1  memory completion for the current access.
REQ-018 stall  out  1  pipeline stall request.
REQ-019 timeout_err  out  1  sticky flag: an access exceeded TIMEOUT.

Function
REQ-020 FSM states SHALL be IDLE, BUSY, DONE; exactly one memory access in flight.
REQ-021 IDLE: if any request is pending, SHALL latch the winner's address/we/wdata into registers and enter BUSY next cycle; else stay IDLE.
REQ-022 Arbitration with both requests pending SHALL be round-robin: grant the requester not granted last; a single pending request always wins.
REQ-023 last-grant register SHALL update only on a grant in IDLE.
REQ-024 BUSY: mem_req=1, and mem_addr/mem_we/mem_wdata SHALL come only from the latched registers, stable for the whole access; mem_we=0 for fetches.
REQ-025 BUSY with mem_ready=1 SHALL capture mem_rdata into the winner's rdata register and enter DONE; mem_ready in the first BUSY cycle is legal.
REQ-026 Wait counter SHALL clear on entering BUSY and increment each BUSY cycle without mem_ready.
REQ-027 When the counter reaches TIMEOUT-1 without mem_ready, the block SHALL abort: enter DONE with rdata=0 and set timeout_err.
REQ-028 timeout_err SHALL stay 1 until reset.
REQ-029 DONE SHALL last exactly one cycle with the winner's done=1, mem_req=0, and then return to IDLE.
REQ-030 Minimum latency from request seen in IDLE to done: 2 cycles (grant, BUSY with ready, then DONE).
REQ-031 A requester dropping req in its done cycle SHALL NOT be re-granted; one still holding req SHALL be treated as a new request.
REQ-032 mem_ready outside BUSY SHALL be ignored.
REQ-033 stall SHALL equal (if_req & ~if_done) | (dm_req & ~dm_done), combinationally.
REQ-034 rdata outputs SHALL hold their last captured value outside done cycles.

Reset
REQ-035 reset=0 SHALL asynchronously force: state IDLE; mem_req, mem_we, if_done, dm_done and timeout_err = 0; latched registers and rdata = 0; wait counter 0; last-grant = fetch, so the first tie goes to data.
REQ-036 Reset asserted mid-BUSY SHALL abandon the access with no done pulse; a late mem_ready SHALL be ignored.

Verification
REQ-037 Fetch only: if_req, if_addr=0x40, mem_ready in the first BUSY cycle with mem_rdata=0x8C0A0004 -> mem_req for 1 cycle; if_done pulse 2 cycles after the request; if_rdata=0x8C0A0004.
REQ-038 Tie after reset: if_req and dm_req in the same cycle (store, addr 0x100, data 0xDEADBEEF) -> data served first with mem_we=1; fetch served next; stall=1 until each done.
REQ-039 Repeated ties: both requests held across 4 accesses -> grants alternate D, I, D, I.
REQ-040 Slow memory: mem_ready delayed 5 cycles -> mem_addr/mem_wdata stable for all 6 BUSY cycles; done after the ready; timeout_err=0.
REQ-041 Timeout with TIMEOUT=16: mem_ready never asserted -> abort after 16 BUSY cycles; done pulse with rdata=0; timeout_err=1 and held.
REQ-042 Reset in BUSY: reset=0 at the 2nd BUSY cycle, then mem_ready -> no done pulse; all outputs 0; next request arbitrated normally.
